// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a status-tagged receive FIFO.
//   The serial input passes through a 2-flop synchroniser. Each bit lasts
//   OVERSAMPLE rx_clk cycles. Each bit is decided by a 3-sample majority vote
//   around mid-bit, which also rejects false start bits. The receiver handles
//   5..MAX_LEN data bits, optional parity and 1 or 2 stop bits, and detects
//   break frames. Received frames enter a FIFO that is read through valid/ready.
//
// Ports
//   rx_clk       oversample clock
//   rst          synchronous, active-high reset
//   rx           asynchronous serial input, idle high
//   rx_en        enables start-bit detection (a frame in flight always completes)
//   length       data bits per frame, clamped to 5..MAX_LEN when latched
//   parity_en    parity bit follows the data
//   parity_type  1: even parity, 0: odd parity
//   stop2        two stop bits
//   m_data       head entry data, right-justified, upper bits 0 (0 when empty)
//   m_perr       head entry parity error tag
//   m_ferr       head entry framing error tag
//   m_valid      FIFO holds at least one entry
//   m_ready      consumer accepts the head entry
//   fifo_count   occupied FIFO entries
//   overrun      sticky: a frame was dropped because the FIFO was full
//   overrun_clr  clears overrun (a same-cycle set wins)
//   break_det    one-cycle pulse when a break frame completes
//   rx_busy      receiver FSM is not idle
//   dbg_state    current receiver FSM state
//
// Handshake: the head entry transfers on every rising rx_clk edge where
//   m_valid && m_ready. m_data/m_perr/m_ferr stay stable while m_valid is high
//   and m_ready is low. The consumer may raise m_ready at any time.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int MAX_LEN    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              rx_clk,
  input  logic                              rst,
  input  logic                              rx,
  input  logic                              rx_en,
  input  logic [3:0]                        length,
  input  logic                              parity_en,
  input  logic                              parity_type,
  input  logic                              stop2,
  output logic [MAX_LEN-1:0]                m_data,
  output logic                              m_perr,
  output logic                              m_ferr,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overrun,
  input  logic                              overrun_clr,
  output logic                              break_det,
  output logic                              rx_busy,
  output logic [2:0]                        dbg_state
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(MAX_LEN);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = MAX_LEN + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_VOTE = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_FIN  = CW'(OVERSAMPLE / 2 + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  // synchroniser and edge detect
  logic sync1_q, rxs_q, prev_q;

  // receiver state
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       bit_q, bit_d;
  logic [MAX_LEN-1:0]  data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                pzero_q, pzero_d;    // parity bit sampled 0 (or no parity)
  logic                s1zero_q, s1zero_d;  // first stop bit sampled 0
  logic                samp_a_q, samp_a_d;
  logic                samp_b_q, samp_b_d;

  // frame configuration latched at the start edge
  logic [IW-1:0]       last_q, last_d;
  logic                par_en_q, par_en_d;
  logic                par_even_q, par_even_d;
  logic                stop2_q, stop2_d;
  logic [3:0]          len_clamp;

  logic                vote, at_vote, at_fin, cnt_wrap;
  logic                finish, is_break, push_req, brk_pulse, exp_par;
  logic                break_q;

  // FIFO
  logic [WW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]       count_q, count_d;
  logic                overrun_q, overrun_d;
  logic                full, pop, push_ok, ovr_set;
  logic [WW-1:0]       head, push_word;

  assign at_vote  = (cnt_q == CNT_VOTE);
  assign at_fin   = (cnt_q == CNT_FIN);
  assign cnt_wrap = (cnt_q == CNT_LAST);
  // The third sample is the live synchronised value at CNT_VOTE.
  assign vote     = (samp_a_q & samp_b_q) | (samp_a_q & rxs_q) | (samp_b_q & rxs_q);
  assign exp_par  = par_even_q ? ^data_q : ~^data_q;
  assign is_break = (data_q == '0) && pzero_q && s1zero_q;

  always_comb begin
    len_clamp = length;
    if (length < 4'd5)                   len_clamp = 4'd5;
    else if (length > 4'(MAX_LEN))       len_clamp = 4'(MAX_LEN);
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pzero_q    <= 1'b1;
      s1zero_q   <= 1'b0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      last_q     <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      stop2_q    <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      prev_q     <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      pzero_q    <= pzero_d;
      s1zero_q   <= s1zero_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      last_q     <= last_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      stop2_q    <= stop2_d;
      break_q    <= brk_pulse;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_wrap ? '0 : cnt_q + CW'(1);
    bit_d      = bit_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    pzero_d    = pzero_q;
    s1zero_d   = s1zero_q;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    last_d     = last_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    stop2_d    = stop2_q;
    finish     = 1'b0;
    push_req   = 1'b0;
    brk_pulse  = 1'b0;

    if (cnt_q == CNT_S0) samp_a_d = rxs_q;
    if (cnt_q == CNT_S1) samp_b_d = rxs_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_en && prev_q && !rxs_q) begin
          state_d    = S_START;
          bit_d      = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          pzero_d    = 1'b1;
          s1zero_d   = 1'b0;
          last_d     = IW'(len_clamp - 4'd1);
          par_en_d   = parity_en;
          par_even_d = parity_type;
          stop2_d    = stop2;
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          state_d = S_IDLE;   // glitch shorter than half a bit
          cnt_d   = '0;
        end else if (cnt_wrap) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_vote) data_d[bit_q] = vote;
        if (cnt_wrap) begin
          if (bit_q == last_q) state_d = par_en_q ? S_PARITY : S_STOP1;
          else                 bit_d   = bit_q + IW'(1);
        end
      end
      S_PARITY: begin
        if (at_vote) begin
          perr_d  = (vote != exp_par);
          pzero_d = !vote;
        end
        if (cnt_wrap) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (at_vote) begin
          ferr_d   = !vote;
          s1zero_d = !vote;
        end
        if (stop2_q) begin
          if (cnt_wrap) state_d = S_STOP2;
        end else if (at_fin) begin
          finish = 1'b1;
        end
      end
      S_STOP2: begin
        if (at_vote) ferr_d = ferr_q | !vote;
        if (at_fin)  finish = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Returning to IDLE at mid-stop lets the next start edge be caught early.
    if (finish) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (is_break) brk_pulse = 1'b1;
      else          push_req  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  assign push_word = {perr_q, ferr_q, data_q};
  assign full      = (count_q == NW'(FIFO_DEPTH));
  assign pop       = m_valid && m_ready;
  // When the FIFO is full, a same-cycle pop frees the slot the push needs.
  assign push_ok   = push_req && (!full || pop);
  assign ovr_set   = push_req && full && !pop;

  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop)     rd_d = rd_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    if (ovr_set)          overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; entries are visible only through count_q.
  always_ff @(posedge rx_clk) begin
    if (!rst && push_ok) mem_q[wr_q] <= push_word;
  end

  assign head       = mem_q[rd_q];
  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? head[MAX_LEN-1:0] : '0;
  assign m_ferr     = m_valid ? head[MAX_LEN]     : 1'b0;
  assign m_perr     = m_valid ? head[MAX_LEN+1]   : 1'b0;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (OVERSAMPLE=16, MAX_LEN=8, FIFO_DEPTH=4).
//   The stimulus drives serial frames on rx. The expected FIFO words
//   {perr, ferr, data} are queued when a frame is sent. A monitor pops and
//   compares each word when the DUT hands it over.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int OS    = 16;
  localparam int ML    = 8;
  localparam int DEPTH = 4;

  // clock / reset
  logic rx_clk = 1'b0;
  logic rst;
  always #5 rx_clk = ~rx_clk;

  logic       rx, rx_en, parity_en, parity_type, stop2, m_ready, overrun_clr;
  logic [3:0] length;
  logic [7:0] m_data;
  logic       m_perr, m_ferr, m_valid, overrun, break_det, rx_busy;
  logic [2:0] fifo_count;
  logic [2:0] dbg_state;

  uart_rx_fifo #(.OVERSAMPLE(OS), .MAX_LEN(ML), .FIFO_DEPTH(DEPTH)) dut (
    .rx_clk      (rx_clk),
    .rst         (rst),
    .rx          (rx),
    .rx_en       (rx_en),
    .length      (length),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .m_data      (m_data),
    .m_perr      (m_perr),
    .m_ferr      (m_ferr),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .break_det   (break_det),
    .rx_busy     (rx_busy),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // values captured in the last stop bit of a frame
  bit fin_seen, fin_valid, fin_brk, fin_brk_next;
  int fin_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every accepted head entry must match the oldest expected word.
  always @(negedge rx_clk) begin
    #1;
    if (!rst && m_valid && m_ready) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("pop_entry", {22'd0, m_perr, m_ferr, m_data}, {22'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b, input bit glitch);
    rx = b;
    repeat (OS / 2) @(negedge rx_clk);
    if (glitch) rx = ~b;
    @(negedge rx_clk);
    rx = b;
    repeat (OS / 2 - 1) @(negedge rx_clk);
  endtask

  // Sends one frame. The config inputs are scrambled after the start bit so
  // that the frame depends only on the values latched at the start edge.
  task automatic send_frame(input logic [7:0] d, input int len, input bit pe, input bit ev,
                            input bit s2, input bit flip_par, input bit stop_v,
                            input int glitch_bit);
    int         eff;
    logic [7:0] dm;
    logic       par;
    eff = (len < 5) ? 5 : ((len > ML) ? ML : len);
    dm  = 8'h00;
    for (int i = 0; i < eff; i++) dm[i] = d[i];
    par = ev ? ^dm : ~^dm;
    if (flip_par) par = ~par;
    length = 4'(len); parity_en = pe; parity_type = ev; stop2 = s2;
    drive_bit(1'b0, 1'b0);
    length = 4'd6; parity_en = ~pe; parity_type = ~ev; stop2 = ~s2;
    for (int i = 0; i < eff; i++) drive_bit(dm[i], (i == glitch_bit));
    if (pe) drive_bit(par, 1'b0);
    if (s2) drive_bit(1'b1, 1'b0);
    rx = stop_v;
    fin_seen = 0; fin_valid = 0; fin_brk = 0; fin_brk_next = 0; fin_i = 0;
    for (int i = 0; i < OS; i++) begin
      @(negedge rx_clk);
      if (fin_seen && (i == fin_i + 1)) fin_brk_next = break_det;
      if (!fin_seen && !rx_busy) begin
        fin_seen = 1; fin_i = i; fin_valid = m_valid; fin_brk = break_det;
      end
    end
    rx = 1'b1;
    repeat (OS) @(negedge rx_clk);
    check("frame_finished", 32'(fin_seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rx_en = 1'b0; m_ready = 1'b0; overrun_clr = 1'b0;
    length = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge rx_clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    rst = 1'b0;
    @(negedge rx_clk);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_break", 32'(break_det), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rx_en = 1'b1; m_ready = 1'b1;
    repeat (OS) @(negedge rx_clk);

    // 8N1 0xA5; m_valid must be high the cycle after finish
    exp_q.push_back({2'b00, 8'hA5});
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, -1);
    check("a5_valid_after_finish", 32'(fin_valid), 32'd1);

    // 5E2 0x13 with a wrong parity bit
    exp_q.push_back({2'b10, 8'h13});
    send_frame(8'h13, 5, 1, 1, 1, 1, 1, -1);

    // 8N1 0x3C with the stop bit held low
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0, -1);
    check("ferr_no_break", 32'(fin_brk), 32'd0);

    // 7O1 0x55, good parity, one-sample glitch at mid-point of data bit 3
    exp_q.push_back({2'b00, 8'h55});
    send_frame(8'h55, 7, 1, 0, 0, 0, 1, 3);

    // length clamping: 3 -> 5 bits, 12 -> 8 bits
    exp_q.push_back({2'b00, 8'h1F});
    send_frame(8'hFF, 3, 0, 0, 0, 0, 1, -1);
    exp_q.push_back({2'b00, 8'h96});
    send_frame(8'h96, 12, 0, 0, 0, 0, 1, 6);

    // short low pulse in IDLE: false start, no entry
    rx = 1'b0;
    repeat (OS / 4) @(negedge rx_clk);
    rx = 1'b1;
    repeat (2) @(negedge rx_clk);
    check("glitch_busy_high", 32'(rx_busy), 32'd1);
    repeat (8) @(negedge rx_clk);
    check("glitch_busy_low", 32'(rx_busy), 32'd0);
    repeat (OS) @(negedge rx_clk);
    check("glitch_no_push", 32'(fifo_count), 32'd0);

    // no start while rx_en is low
    rx_en = 1'b0; rx = 1'b0;
    repeat (OS) @(negedge rx_clk);
    check("rx_en_low_idle", 32'(rx_busy), 32'd0);
    rx = 1'b1;
    repeat (OS) @(negedge rx_clk);
    rx_en = 1'b1;

    // 8E1 all-zero frame: break pulse, nothing stored
    send_frame(8'h00, 8, 1, 1, 0, 0, 0, -1);
    check("break_pulse", 32'(fin_brk), 32'd1);
    check("break_one_cycle", 32'(fin_brk_next), 32'd0);
    check("break_no_push", 32'(fifo_count), 32'd0);

    // five frames with the consumer stalled: four stored, overrun set
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back({2'b00, 8'(i)});
      send_frame(8'(i), 8, 0, 0, 0, 0, 1, -1);
    end
    check("full_count", 32'(fifo_count), 32'd4);
    check("overrun_set", 32'(overrun), 32'd1);
    check("full_head", 32'(m_data), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge rx_clk);
      if (fifo_count == 3'd0) break;
    end
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_scoreboard", 32'(exp_q.size()), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge rx_clk);
    overrun_clr = 1'b0;
    @(negedge rx_clk);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // reset in the middle of a frame flushes everything
    m_ready = 1'b0;
    send_frame(8'h77, 8, 0, 0, 0, 0, 1, -1);
    check("pre_reset_count", 32'(fifo_count), 32'd1);
    rx = 1'b0;
    repeat (3 * OS) @(negedge rx_clk);
    check("pre_reset_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge rx_clk);
    rx = 1'b1; rst = 1'b0;
    @(negedge rx_clk);
    check("mid_reset_busy", 32'(rx_busy), 32'd0);
    check("mid_reset_count", 32'(fifo_count), 32'd0);
    check("mid_reset_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    repeat (OS) @(negedge rx_clk);

    // normal reception after reset
    exp_q.push_back({2'b00, 8'hC3});
    send_frame(8'hC3, 8, 0, 0, 0, 0, 1, -1);
    repeat (4) @(negedge rx_clk);
    check("final_scoreboard", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(fifo_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
